// File: rtl/hamming_weight.sv
// hamming_weight: 16-bit population counter built as a 4-edge adder tree.
// One operation in flight; result strobed on hw_vld for exactly one cycle.

// Per-lane level-1 counter: number of set bits in one 2-bit pair.
module hw_pair_cnt (
    input  logic [1:0] bits,
    output logic [1:0] cnt
);
    assign cnt = {1'b0, bits[1]} + {1'b0, bits[0]};
endmodule

module hamming_weight (
    input  logic        clk,
    input  logic        rst_n,     // active-high asynchronous reset
    input  logic        op_start,
    input  logic [15:0] din,
    output logic        hw_vld,
    output logic [4:0]  hamW
);
    localparam int NUM_PAIRS = 8;

    typedef enum logic [2:0] {IDLE, L1, L2, L3, DONE} state_t;

    state_t                     state;
    logic [NUM_PAIRS-1:0][1:0]  lvl1_d;
    logic [7:0][1:0]            lvl1;   // pair counts, 0..2
    logic [3:0][2:0]            lvl2;   // nibble counts, 0..4
    logic [1:0][3:0]            lvl3;   // byte counts, 0..8
    logic [3:0][2:0]            lvl2_d;
    logic [1:0][3:0]            lvl3_d;
    logic [4:0]                 total;

    // Level-1 pair counters, one instance per 2-bit lane of din
    genvar g;
    generate
        for (g = 0; g < NUM_PAIRS; g++) begin : g_pair
            hw_pair_cnt u_pair (
                .bits(din[2*g+1:2*g]),
                .cnt (lvl1_d[g])
            );
        end
    endgenerate

    // Next-level sums; each level widens by one bit so nothing can overflow
    always_comb begin
        for (int i = 0; i < 4; i++)
            lvl2_d[i] = 3'(lvl1[2*i]) + 3'(lvl1[2*i+1]);
        for (int i = 0; i < 2; i++)
            lvl3_d[i] = 4'(lvl2[2*i]) + 4'(lvl2[2*i+1]);
        total = 5'(lvl3[0]) + 5'(lvl3[1]);
    end

    // Sequencer: advances one tree level per edge, registers result and strobe.
    // din is only captured on the accepting edge (IDLE or DONE with op_start).
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= IDLE;
            lvl1   <= '0;
            lvl2   <= '0;
            lvl3   <= '0;
            hw_vld <= 1'b0;
            hamW   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_start) begin
                        lvl1  <= lvl1_d;
                        state <= L1;
                    end
                end
                L1: begin
                    lvl2  <= lvl2_d;
                    state <= L2;
                end
                L2: begin
                    lvl3  <= lvl3_d;
                    state <= L3;
                end
                L3: begin
                    hamW   <= total;
                    hw_vld <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    hw_vld <= 1'b0;
                    if (op_start) begin
                        lvl1  <= lvl1_d;
                        state <= L1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    hw_vld <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hamming_weight.sv
// Directed bench for hamming_weight: reset, counts, extremes, ignored
// restarts, back-to-back ops and mid-operation reset.
module tb_hamming_weight;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_start = 1'b0;
    logic [15:0] din = '0;
    logic        hw_vld;
    logic [4:0]  hamW;

    int checks = 0;
    int errors = 0;

    hamming_weight dut (
        .clk     (clk),
        .rst_n   (rst),
        .op_start(op_start),
        .din     (din),
        .hw_vld  (hw_vld),
        .hamW    (hamW)
    );

    always #5 clk = ~clk;

    // Pulse op_start for one cycle; returns at the negedge after the capture edge
    task automatic start_op(input logic [15:0] d);
        @(negedge clk);
        op_start = 1'b1;
        din      = d;
        @(negedge clk);
        op_start = 1'b0;
        din      = 16'hA5A5;
    endtask

    // Observe n negedges (position 1 = current one); record strobes
    task automatic watch(input int n, output int cnt, output int first,
                         output logic [4:0] val, output logic [4:0] last_hw);
        cnt = 0; first = -1; val = '0;
        for (int i = 1; i <= n; i++) begin
            if (i > 1) @(negedge clk);
            if (hw_vld === 1'b1) begin
                cnt++;
                if (first < 0) begin
                    first = i;
                    val   = hamW;
                end
            end
        end
        last_hw = hamW;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (hw_vld !== 1'b0 || hamW !== 5'd0) begin
            errors++;
            $display("FAIL reset_hold: hw_vld=%b hamW=%0d, want 0/0", hw_vld, hamW);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (hw_vld !== 1'b0 || hamW !== 5'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: hw_vld=%b hamW=%0d, want 0/0", i, hw_vld, hamW);
            end
        end
    endtask

    task automatic test_count(input string name, input logic [15:0] d, input logic [4:0] exp);
        int cnt, first;
        logic [4:0] val, last_hw;
        start_op(d);
        watch(8, cnt, first, val, last_hw);
        checks++;
        if (cnt !== 1 || first !== 4) begin
            errors++;
            $display("FAIL %s_strobe: count=%0d pos=%0d, want 1 at 4", name, cnt, first);
        end
        checks++;
        if (val !== exp) begin
            errors++;
            $display("FAIL %s_value: hamW=%0d, want %0d", name, val, exp);
        end
        checks++;
        if (last_hw !== exp) begin
            errors++;
            $display("FAIL %s_hold: hamW=%0d, want %0d", name, last_hw, exp);
        end
    endtask

    task automatic test_ignore_restart;
        int cnt = 0, first = -1;
        logic [4:0] val = '0;
        start_op(16'h0003);
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) @(negedge clk);
            if (hw_vld === 1'b1) begin
                cnt++;
                if (first < 0) begin first = i; val = hamW; end
            end
            // re-pulse sampled at edges where the FSM is in L1, L2, L3
            op_start = (i <= 3);
            din      = 16'hFFFF;
        end
        op_start = 1'b0;
        checks++;
        if (cnt !== 1 || first !== 4) begin
            errors++;
            $display("FAIL ignore_strobe: count=%0d pos=%0d, want 1 at 4", cnt, first);
        end
        checks++;
        if (val !== 5'd2) begin
            errors++;
            $display("FAIL ignore_value: hamW=%0d, want 2", val);
        end
    endtask

    task automatic test_back_to_back;
        int cnt = 0;
        int pos[2] = '{-1, -1};
        logic [4:0] v[2] = '{5'd0, 5'd0};
        start_op(16'h8001);
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) @(negedge clk);
            if (hw_vld === 1'b1) begin
                if (cnt < 2) begin pos[cnt] = i; v[cnt] = hamW; end
                cnt++;
            end
            // second op offered while in DONE, accepted on the next edge
            op_start = (i == 4);
            din      = (i == 4) ? 16'h7F00 : 16'h0000;
        end
        op_start = 1'b0;
        checks++;
        if (cnt !== 2 || pos[0] !== 4 || pos[1] !== 8) begin
            errors++;
            $display("FAIL b2b_strobe: count=%0d pos=%0d,%0d, want 2 at 4,8", cnt, pos[0], pos[1]);
        end
        checks++;
        if (v[0] !== 5'd2 || v[1] !== 5'd7) begin
            errors++;
            $display("FAIL b2b_value: hamW=%0d,%0d, want 2,7", v[0], v[1]);
        end
    endtask

    task automatic test_reset_mid_op;
        int cnt, first;
        logic [4:0] val, last_hw;
        start_op(16'hFFFF);      // now in L1
        @(negedge clk);          // now in L2
        rst = 1'b1;
        #1;
        checks++;
        if (hw_vld !== 1'b0 || hamW !== 5'd0) begin
            errors++;
            $display("FAIL midrst_clear: hw_vld=%b hamW=%0d, want 0/0", hw_vld, hamW);
        end
        @(negedge clk);
        rst = 1'b0;
        watch(8, cnt, first, val, last_hw);
        checks++;
        if (cnt !== 0 || last_hw !== 5'd0) begin
            errors++;
            $display("FAIL midrst_abort: strobes=%0d hamW=%0d, want 0/0", cnt, last_hw);
        end
        test_count("after_rst", 16'h00F0, 5'd4);
    endtask

    initial begin
        test_reset();
        test_count("one",   16'd1,     5'd1);
        test_count("mixed", 16'd27834, 5'd9);
        test_count("ones",  16'hFFFF,  5'd16);
        test_count("zeros", 16'h0000,  5'd0);
        test_count("alt",   16'h5555,  5'd8);
        test_ignore_restart();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end
endmodule
